// File: rtl/run_sequencer_pkg.sv
// Shared types and helpers for the run sequencer: FSM states and ASCII encoding.
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StReport,
    StDone
  } state_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Byte stream from the run sequencer to the UART transmitter (valid/ready).
interface run_sequencer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/run_sequencer_sync_rise.sv
// Two-flop synchronizer for an asynchronous level, plus a one-cycle rising-edge pulse.
module sync_rise (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: one start pulse per run edge, counts cycles to dp_done,
// latches the count and reports it as uppercase hex + CR LF over the tx stream.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter bit          REPORT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    output logic               start,
    input  logic               dp_done,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cycles,
    run_sequencer_if.master    tx
);

    localparam int unsigned NDIG   = CNT_W / 4;
    localparam int unsigned NBYTES = NDIG + 2;
    localparam int unsigned IDX_W  = $clog2(NBYTES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d, cnt_inc;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               run_rise;
    logic [7:0]         msg [NBYTES];
    logic [7:0]         cur_byte;
    logic [7:0]         tx_data_c;
    logic               tx_valid_c;

    sync_rise u_sync_run (
        .clk  (clk),
        .rstn (rstn),
        .din  (run),
        .rise (run_rise)
    );

    assign cnt_inc = (&counter_q) ? counter_q : counter_q + 1'b1;

    // Report message, most-significant nibble first.
    always_comb begin
        for (int i = 0; i < int'(NDIG); i++) begin
            msg[i] = hex_ascii(cycles_q[4*(int'(NDIG)-1-i) +: 4]);
        end
        msg[NDIG]     = CR;
        msg[NDIG + 1] = LF;
        cur_byte      = (int'(idx_q) < int'(NBYTES)) ? msg[idx_q] : 8'h00;
    end

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        cycles_d   = cycles_q;
        idx_d      = idx_q;
        start      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        case (state_q)
            StIdle: begin
                if (run_rise) state_d = StStart;
            end
            StStart: begin
                start     = 1'b1;
                busy      = 1'b1;
                counter_d = '0;
                state_d   = StRun;
            end
            StRun: begin
                busy      = 1'b1;
                counter_d = cnt_inc;
                if (dp_done) begin
                    cycles_d = cnt_inc;
                    idx_d    = '0;
                    state_d  = REPORT_EN ? StReport : StDone;
                end
            end
            StReport: begin
                busy       = 1'b1;
                tx_valid_c = 1'b1;
                tx_data_c  = cur_byte;
                if (tx.tx_ready) begin
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
                if (run_rise) state_d = StStart;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            counter_q <= '0;
            cycles_q  <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            cycles_q  <= cycles_d;
            idx_q     <= idx_d;
        end
    end

    assign cycles      = cycles_q;
    assign tx.tx_data  = tx_data_c;
    assign tx.tx_valid = tx_valid_c;

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Top-level run controller for the lab accelerator datapath.
- Turns the raw `run` button/switch into a single start pulse to the datapath and counts clock cycles until the datapath signals completion.
- Latches the count for the `cycles` display output.
- Streams the count as ASCII hex plus CR LF to the UART transmitter through a valid/ready byte handshake, then holds `done`.

Parameters:
- CNT_W, 16, cycle counter / `cycles` width; multiple of 4, range 4..32.
- REPORT_EN, 1, 1 = send UART report after completion; 0 = skip the REPORT state.
- NDIG, CNT_W/4, number of hex digits sent (localparam, not overridable).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- run  in  1  raw asynchronous run request; a rising edge starts a run.
- start  out  1  one-cycle pulse to datapath: begin operation.
- dp_done  in  1  datapath completion, synchronous to clk, sampled only in RUN.
- busy  out  1  high in START, RUN and REPORT.
- done  out  1  high in DONE only.
- cycles  out  CNT_W  latched cycle count of the last completed run.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART transmitter accepts byte.

Behaviour:
- Reset (rstn low, asynchronous):
  - State IDLE.
  - start, busy, done, tx_valid = 0; cycles = 0; tx_data = 0.
  - Counter, digit index and synchronizer flops = 0.
- Reset release: synchronous use only; no action until the next run rising edge.
- run input path:
  - run passes through a 2-FF synchronizer, then rising-edge detection against a third flop.
  - Let E0 be the clock edge at which run is first sampled 1. The edge indication is high between E1 and E2.
  - The FSM leaves IDLE/DONE at E2, so start is high for the cycle E2..E3.
- States and transitions:
  - IDLE: on run edge -> START.
  - START: start=1; counter <= 0; unconditionally -> RUN next edge.
  - RUN:
    - counter increments each cycle, saturating at all-ones.
    - If dp_done=1, latch cycles <= sat(counter+1); go to REPORT (REPORT_EN=1) or DONE (REPORT_EN=0).
    - dp_done high in the first RUN cycle gives cycles=1.
  - REPORT:
    - Sends NDIG+2 bytes in order: hex digits most-significant nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46 uppercase), then 0x0D, 0x0A.
    - tx_valid=1 throughout REPORT.
    - tx_data is stable while tx_valid & !tx_ready.
    - A byte completes on a clock edge with tx_valid & tx_ready; the index advances and the next byte is presented the following cycle with no gap.
    - After the last byte is accepted -> DONE; tx_valid=0 in the same edge.
  - DONE: done=1; cycles holds; on run edge -> START (done falls at the same edge start rises).
- Boundary cases:
  - run edges in START, RUN and REPORT are ignored and not queued.
  - dp_done outside RUN is ignored.
  - Counter saturation: cycles=all-ones, report "FFFF" for CNT_W=16; no wrap.
  - tx_ready held low forever: REPORT stalls indefinitely; only reset exits.
  - Reset mid-RUN or mid-REPORT: immediate return to reset values, no partial byte retained; the next run edge starts fresh.
  - run held high continuously yields exactly one start.
- cycles updates only on RUN exit; it is not cleared by a new start.

Decomposition:
- Package run_sequencer_pkg:
  - state enum {IDLE, START, RUN, REPORT, DONE};
  - ASCII constants CR=8'h0D, LF=8'h0A;
  - function hex_ascii(4-bit) -> 8-bit.
- Sub-module sync_rise: 2-FF synchronizer plus edge flop, async active-low reset, output rise pulse. Reusable for other button inputs.
- FSM, counter and byte serializer stay in run_sequencer.

Test Plan:
- Reset: hold rstn=0 for 5 cycles mid-stimulus -> all outputs 0; release, no run -> stays IDLE, no start.
- Basic run: run rises, datapath asserts dp_done on the 10th RUN cycle, tx_ready=1 -> start one cycle at E2; cycles=0x000A; bytes 0x30 0x30 0x30 0x41 0x0D 0x0A on 6 consecutive cycles; then done=1, busy=0.
- Backpressure: cycles=0x1234, tx_ready random 30% high -> exactly 0x31 0x32 0x33 0x34 0x0D 0x0A in order; tx_data stable during every stall; no duplicates.
- Saturation: dp_done never asserted for 70000 cycles, then pulsed -> cycles=0xFFFF; report "FFFF\r\n".
- Ignored/restart: run toggles during RUN -> single start, count unaffected. run rises in DONE -> done falls, a new start pulse, a new count is latched.
- Reset mid-REPORT after 2 bytes -> tx_valid=0 asynchronously, state IDLE, cycles=0; the next run completes a full 6-byte report.
